// File: rtl/led_pattern_monitor.sv
// Checks that an 8-bit LED bus shows one lit LED rotating by one position per sample.
// Define LED_MON_SYNC_EN to pass led_in/sample_en through 2-flop synchronizers.
module led_pattern_monitor #(
  parameter int LOCK_STEPS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       led_in,
  input  logic             sample_en,
  output logic [2:0]       pos,
  output logic             dir,
  output logic             locked,
  output logic [CNT_W-1:0] step_count,
  output logic             err,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {UNSYNC, ACQ, LOCKED} state_t;

  logic [7:0] led_w;
  logic       en_w;

`ifdef LED_MON_SYNC_EN
  logic [7:0] led_s1_q, led_s2_q;
  logic       en_s1_q, en_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_s1_q <= '0;
      led_s2_q <= '0;
      en_s1_q  <= 1'b0;
      en_s2_q  <= 1'b0;
    end else begin
      led_s1_q <= led_in;
      led_s2_q <= led_s1_q;
      en_s1_q  <= sample_en;
      en_s2_q  <= en_s1_q;
    end
  end

  assign led_w = led_s2_q;
  assign en_w  = en_s2_q;
`else
  assign led_w = led_in;
  assign en_w  = sample_en;
`endif

  state_t           state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic [2:0]       pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] step_count_q, step_count_d;
  logic             err_q, err_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [2:0] idx;
  logic       onehot, hold, up, down;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (led_w[i]) idx = 3'(i);
    end
  end

  assign onehot = (led_w != '0) && ((led_w & (led_w - 8'd1)) == '0);
  assign hold   = onehot && (led_w == prev_q);
  assign up     = onehot && (led_w == {prev_q[6:0], prev_q[7]});
  assign down   = onehot && (led_w == {prev_q[0], prev_q[7:1]});

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    cnt_d        = cnt_q;
    locked_d     = locked_q;
    step_count_d = step_count_q;
    err_d        = 1'b0;
    err_count_d  = err_count_q;
    if (en_w) begin
      unique case (state_q)
        UNSYNC: begin
          if (onehot) begin
            prev_d  = led_w;
            pos_d   = idx;
            cnt_d   = '0;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (!onehot) begin
            state_d = UNSYNC;
          end else if (hold) begin
            state_d = ACQ;
          end else if (up || down) begin
            prev_d = led_w;
            pos_d  = idx;
            // The first step only establishes direction; a reversal restarts the run at 1.
            if (cnt_q == '0 || dir_q == up) cnt_d = cnt_q + 4'd1;
            else                            cnt_d = 4'd1;
            dir_d = up;
            if (cnt_d == 4'(LOCK_STEPS)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            prev_d = led_w;
            pos_d  = idx;
            cnt_d  = '0;
          end
        end
        LOCKED: begin
          if (hold) begin
            state_d = LOCKED;
          end else if ((dir_q && up) || (!dir_q && down)) begin
            prev_d = led_w;
            pos_d  = idx;
            if (step_count_q != '1) step_count_d = step_count_q + CNT_W'(1);
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = UNSYNC;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
        end
        default: state_d = UNSYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNSYNC;
      prev_q       <= '0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      cnt_q        <= '0;
      locked_q     <= 1'b0;
      step_count_q <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      locked_q     <= locked_d;
      step_count_q <= step_count_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign pos        = pos_q;
  assign dir        = dir_q;
  assign locked     = locked_q;
  assign step_count = step_count_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule
